// File: rtl/nbitcountdown.sv
// -----------------------------------------------------------------------------
// nbitcountdown
//
// Programmable N-bit down-counter/timer. A reload value is captured into R and
// counted down to zero on qualified COUNT cycles. Terminal count produces a
// one-cycle DONE pulse; with AUTO set the counter reloads from R and keeps
// running instead of stopping.
//
// Ports:
//   CLK    - system clock, all state changes on the rising edge
//   RESET  - synchronous, active-high reset
//   LOAD   - capture `in` into the reload register (and into y unless running)
//   START  - begin a countdown from the reload register
//   STOP   - abort a running countdown, y holds
//   COUNT  - count enable, one decrement per sampled-high cycle while running
//   AUTO   - reload from R at terminal count instead of finishing
//   in     - reload value
//   y      - current count (registered)
//   ZERO   - combinational (y == 0)
//   BUSY   - registered, high while in RUN
//   DONE   - registered one-cycle terminal-count pulse
//
// Control priority on each edge: RESET > STOP > LOAD > START > COUNT.
// -----------------------------------------------------------------------------
module nbitcountdown #(
    parameter int N = 4
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         LOAD,
    input  logic         START,
    input  logic         STOP,
    input  logic         COUNT,
    input  logic         AUTO,
    input  logic [N-1:0] in,
    output logic [N-1:0] y,
    output logic         ZERO,
    output logic         BUSY,
    output logic         DONE
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    state_e       state_q, state_d;
    logic [N-1:0] y_q, y_d;
    logic [N-1:0] r_q, r_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // can leave it unassigned and infer a latch.
        state_d = state_q;
        y_d     = y_q;
        r_d     = r_q;
        done_d  = 1'b0;

        if (STOP) begin
            // Aborting leaves y where it is; in IDLE this is simply a no-op
            // that still masks lower-priority controls.
            state_d = IDLE;
        end else if (LOAD) begin
            r_d = in;
            // While running, a new reload value waits for the next start or
            // auto-reload; elsewhere it is also shown on y immediately.
            if (state_q != RUN) begin
                y_d     = in;
                state_d = IDLE;
            end
        end else if (START && (state_q != RUN)) begin
            if (r_q != '0) begin
                y_d     = r_q;
                state_d = RUN;
            end else begin
                // Zero-length interval: terminal count is immediate.
                y_d     = '0;
                done_d  = 1'b1;
                state_d = FIN;
            end
        end else if (COUNT && (state_q == RUN)) begin
            if (y_q > ONE) begin
                y_d = y_q - ONE;
            end else if (y_q == ONE) begin
                done_d = 1'b1;
                if (AUTO && (r_q != '0)) begin
                    // Reload directly from 1 so y never shows 0 in auto mode.
                    y_d = r_q;
                end else begin
                    y_d     = '0;
                    state_d = FIN;
                end
            end
        end

        busy_d = (state_d == RUN);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            y_q     <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign y    = y_q;
    assign ZERO = (y_q == '0);
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule
